cdb_arbiter: RTL and testbench

Common-data-bus stage sitting directly downstream of the functional units (the Add units attached to each reservation station). Each unit's result is captured into a small per-unit buffer. A round-robin arbiter then drives exactly one tagged result per cycle onto a registered broadcast bus. The register file and reservation-station wakeup logic consume that bus.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/fu_result_fifo.sv | 44 ++++
 rtl/cdb_arbiter.sv | 102 ++++++++++
 tb/tb_cdb_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the common-data-bus record seen by its consumers.
package cpu_pkg;
  localparam int NUM_FU = 8;
  localparam int TAG_W  = $clog2(NUM_FU);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } cdb_t;
endpackage

// File: rtl/fu_result_fifo.sv
// Per-unit result buffer: DEPTH-entry FIFO with registered count and full.
module fu_result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count,
  output logic              full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];
  assign full = (count == CW'(DEPTH));
endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus stage: per-unit result buffers, round-robin grant, registered broadcast.
// Optional macro CDB_STATS_EN adds bcast_count / stall_count statistics ports.
module cdb_arbiter
  import cpu_pkg::*;
#(
  parameter int NUM_FU = cpu_pkg::NUM_FU,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                           CLOCK_50,
  input  logic                           RESET,
  input  logic [NUM_FU-1:0]              fu_valid,
  input  logic [NUM_FU-1:0][DATA_W-1:0]  fu_data,
  output logic [NUM_FU-1:0]              fu_ready,
`ifdef CDB_STATS_EN
  output logic [31:0]                    bcast_count,
  output logic [31:0]                    stall_count,
`endif
  output logic                           cdb_valid,
  output logic [$clog2(NUM_FU)-1:0]      cdb_tag,
  output logic [DATA_W-1:0]              cdb_data
);
  localparam int TW = $clog2(NUM_FU);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NUM_FU-1:0][DATA_W-1:0] head;
  logic [NUM_FU-1:0][CW-1:0]     cnt;
  logic [NUM_FU-1:0]             full, nonempty, push, pop;
  logic [TW-1:0]                 ptr, gnt_idx;
  logic                          gnt_vld;
  logic                          unused_slot0;

  // Slot 0 means "no producer": never buffered, never ready, never granted.
  assign unused_slot0 = ^{fu_valid[0], fu_data[0]};
  assign head[0]      = '0;
  assign cnt[0]       = '0;
  assign full[0]      = 1'b1;
  assign nonempty[0]  = 1'b0;
  assign push[0]      = 1'b0;
  assign pop[0]       = 1'b0;
  assign fu_ready[0]  = 1'b0;

  for (genvar i = 1; i < NUM_FU; i++) begin : g_lane
    assign fu_ready[i] = ~full[i];
    assign push[i]     = fu_valid[i] & ~full[i];
    assign pop[i]      = gnt_vld & (gnt_idx == TW'(i));
    assign nonempty[i] = (cnt[i] != '0);

    fu_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk   (CLOCK_50),
      .rst   (RESET),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (fu_data[i]),
      .head  (head[i]),
      .count (cnt[i]),
      .full  (full[i])
    );
  end

  // Scan slots 1..NUM_FU-1 starting at ptr, wrapping past NUM_FU-1 back to 1.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_FU - 1; k++) begin
      int idx;
      idx = ((int'(ptr) - 1 + k) % (NUM_FU - 1)) + 1;
      if (!gnt_vld && nonempty[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = TW'(idx);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      ptr       <= TW'(1);
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end else begin
      cdb_valid <= gnt_vld;
      if (gnt_vld) begin
        ptr      <= (gnt_idx == TW'(NUM_FU - 1)) ? TW'(1) : gnt_idx + TW'(1);
        cdb_tag  <= gnt_idx;
        cdb_data <= head[gnt_idx];
      end
    end
  end

`ifdef CDB_STATS_EN
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      bcast_count <= '0;
      stall_count <= '0;
    end else begin
      if (cdb_valid) bcast_count <= bcast_count + 32'd1;
      if (|(fu_valid & ~fu_ready & ~NUM_FU'(1))) stall_count <= stall_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed plan plus random traffic vs a queue model.
module tb_cdb_arbiter;
  localparam int NUM_FU = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int TW     = $clog2(NUM_FU);

  logic                          CLOCK_50 = 1'b0;
  logic                          RESET;
  logic [NUM_FU-1:0]             fu_valid;
  logic [NUM_FU-1:0][DATA_W-1:0] fu_data;
  logic [NUM_FU-1:0]             fu_ready;
  logic                          cdb_valid;
  logic [TW-1:0]                 cdb_tag;
  logic [DATA_W-1:0]             cdb_data;
`ifdef CDB_STATS_EN
  logic [31:0] bcast_count, stall_count;
`endif

  cdb_arbiter #(.NUM_FU(NUM_FU), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .fu_valid (fu_valid),
    .fu_data  (fu_data),
    .fu_ready (fu_ready),
`ifdef CDB_STATS_EN
    .bcast_count (bcast_count),
    .stall_count (stall_count),
`endif
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct { int tag; logic [31:0] data; } bc_t;

  int total = 0;
  int bad   = 0;

  // Reference model: upstream source queues, buffered queues, rr pointer, last bus value.
  logic [31:0] src [NUM_FU][$];
  logic [31:0] q   [NUM_FU][$];
  bc_t         log_q[$];
  int          mptr;
  bit          e_valid;
  int          e_tag;
  logic [31:0] e_data;
  logic [31:0] m_bcast, m_stall;
  bit          saw_rdy4_low;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_FU; i++) begin
      src[i].delete();
      q[i].delete();
    end
    mptr = 1; e_valid = 0; e_tag = 0; e_data = '0;
    m_bcast = '0; m_stall = '0;
  endtask

  task automatic check_outputs();
    check("cdb_valid", {63'd0, cdb_valid}, {63'd0, e_valid});
    check("cdb_tag",   64'(cdb_tag),       64'(e_tag));
    check("cdb_data",  64'(cdb_data),      64'(e_data));
`ifdef CDB_STATS_EN
    check("bcast_count", 64'(bcast_count), 64'(m_bcast));
    check("stall_count", 64'(stall_count), 64'(m_stall));
`endif
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    fu_valid = '0;
    fu_data  = '0;
    @(posedge CLOCK_50); #1;
    RESET = 1'b0;
    model_clear();
    check("rst_ready", 64'(fu_ready), 64'(8'hFE));
    check_outputs();
  endtask

  // One clock: present source heads, check ready, advance model and DUT, check bus.
  task automatic tick();
    logic [NUM_FU-1:0] v, rdy;
    logic [NUM_FU-1:0][DATA_W-1:0] d;
    int g;
    v = '0; d = '0; rdy = '0;
    for (int i = 1; i < NUM_FU; i++) begin
      if (src[i].size() > 0) begin v[i] = 1'b1; d[i] = src[i][0]; end
      rdy[i] = (q[i].size() < DEPTH);
    end
    fu_valid = v;
    fu_data  = d;
    #1;
    check("fu_ready", 64'(fu_ready), 64'(rdy));
    if (!fu_ready[4]) saw_rdy4_low = 1;
    g = 0;
    for (int k = 0; k < NUM_FU - 1; k++) begin
      int idx;
      idx = ((mptr - 1 + k) % (NUM_FU - 1)) + 1;
      if (g == 0 && q[idx].size() > 0) g = idx;
    end
    if (e_valid) m_bcast++;
    if ((v & ~rdy) != '0) m_stall++;
    @(posedge CLOCK_50); #1;
    if (g != 0) begin
      bc_t b;
      e_valid = 1; e_tag = g; e_data = q[g].pop_front();
      mptr = (g == NUM_FU - 1) ? 1 : g + 1;
      b.tag = g; b.data = e_data;
      log_q.push_back(b);
    end else begin
      e_valid = 0;
    end
    for (int i = 1; i < NUM_FU; i++) begin
      if (v[i] && rdy[i]) begin
        q[i].push_back(d[i]);
        void'(src[i].pop_front());
      end
    end
    check_outputs();
  endtask

  function automatic bit drained();
    for (int i = 1; i < NUM_FU; i++)
      if (src[i].size() > 0 || q[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic run_until_drained(input string tag);
    int n;
    n = 0;
    while (!drained() && n < 200) begin tick(); n++; end
    tick();
    check({tag, "_drain"}, {63'd0, drained()}, 64'd1);
  endtask

  initial begin
    int c4, cnt[NUM_FU];
    logic [31:0] u4[$];
    RESET = 1'b1;
    fu_valid = '0;
    fu_data  = '0;
    model_clear();
    repeat (2) @(posedge CLOCK_50);
    #1;

    // Single push, unit 3 value 5.
    do_reset();
    log_q.delete();
    src[3].push_back(32'h5);
    tick();
    check("t1_idle_after_push", {63'd0, cdb_valid}, 64'd0);
    tick();
    check("t1_valid", {63'd0, cdb_valid}, 64'd1);
    check("t1_tag",   64'(cdb_tag), 64'd3);
    check("t1_data",  64'(cdb_data), 64'd5);
    repeat (3) tick();
    check("t1_count", 64'(log_q.size()), 64'd1);

    // Units 1, 2, 5 push together with ptr at 1.
    do_reset();
    log_q.delete();
    src[1].push_back(32'h11); src[2].push_back(32'h22); src[5].push_back(32'h55);
    run_until_drained("t2");
    check("t2_count", 64'(log_q.size()), 64'd3);
    if (log_q.size() == 3) begin
      check("t2_b0", {32'(log_q[0].tag), log_q[0].data}, {32'd1, 32'h11});
      check("t2_b1", {32'(log_q[1].tag), log_q[1].data}, {32'd2, 32'h22});
      check("t2_b2", {32'(log_q[2].tag), log_q[2].data}, {32'd5, 32'h55});
    end

    // Back-pressure on unit 4 while units 1-3 compete.
    do_reset();
    log_q.delete();
    saw_rdy4_low = 0;
    for (int n = 0; n < 6; n++)
      for (int i = 1; i <= 3; i++) src[i].push_back(32'h100 * i + n);
    src[4].push_back(32'hA); src[4].push_back(32'hB); src[4].push_back(32'hC);
    run_until_drained("t3");
    u4.delete();
    foreach (log_q[k]) if (log_q[k].tag == 4) u4.push_back(log_q[k].data);
    check("t3_rdy4_dropped", {63'd0, saw_rdy4_low}, 64'd1);
    check("t3_u4_count", 64'(u4.size()), 64'd3);
    if (u4.size() == 3)
      check("t3_u4_order", {u4[0][15:0], u4[1][15:0], u4[2][15:0]}, {16'hA, 16'hB, 16'hC});
    check("t3_total", 64'(log_q.size()), 64'd21);

    // Fairness: all seven units loaded, 21 consecutive broadcasts.
    do_reset();
    log_q.delete();
    for (int n = 0; n < 3; n++)
      for (int i = 1; i < NUM_FU; i++) src[i].push_back(32'h1000 * i + n);
    run_until_drained("t4");
    for (int i = 0; i < NUM_FU; i++) cnt[i] = 0;
    c4 = 0;
    foreach (log_q[k]) begin
      cnt[log_q[k].tag]++;
      if (log_q[k].tag != (k % 7) + 1) c4++;
    end
    check("t4_total", 64'(log_q.size()), 64'd21);
    check("t4_seq_errs", 64'(c4), 64'd0);
    for (int i = 1; i < NUM_FU; i++) check("t4_per_tag", 64'(cnt[i]), 64'd3);

    // Reset with results buffered: nothing stale may appear afterwards.
    do_reset();
    log_q.delete();
    for (int i = 1; i <= 4; i++) src[i].push_back(32'hDEAD_0000 + i);
    tick();
    check("t5_buffered", 64'(q[1].size() + q[2].size() + q[3].size() + q[4].size()), 64'd4);
    do_reset();
    log_q.delete();
    check("t5_valid", {63'd0, cdb_valid}, 64'd0);
    check("t5_ready", 64'(fu_ready), 64'(8'hFE));
    repeat (5) tick();
    check("t5_no_stale", 64'(log_q.size()), 64'd0);

    // Random traffic against the model, including the statistics counters.
    do_reset();
    log_q.delete();
    for (int c = 0; c < 400; c++) begin
      for (int i = 1; i < NUM_FU; i++)
        if (src[i].size() == 0 && $urandom_range(0, 99) < 45) src[i].push_back($urandom);
      tick();
    end
    run_until_drained("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
